// File: rtl/seq_signed_divider.sv
// Iterative restoring divider: signed NW-bit dividend by unsigned DW-bit divisor.
// Quotient truncates toward zero and the remainder takes the dividend's sign.
// Each divide works on the dividend's magnitude, one quotient bit per cycle.
// A final FIX cycle applies the dividend's sign to the result.
// Valid/ready handshakes on both sides, with one operation in flight at a time.
module seq_signed_divider #(
  parameter int unsigned NW = 5,
  parameter int unsigned DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] quotient,
  output logic [DW:0]   remainder,
  output logic          div_by_zero
);

  localparam int unsigned CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_t;

  state_t        state;
  logic [CW-1:0] cnt;      // current quotient bit, NW-1 down to 0
  logic [NW-1:0] mag;      // |dividend| as unsigned; the minimum value maps to 2^(NW-1)
  logic [NW-1:0] q_acc;    // unsigned quotient being built
  logic [DW-1:0] dvs;      // captured divisor
  logic [DW:0]   p;        // partial remainder, always < dvs between steps
  logic          neg;      // dividend was negative
  logic          dz_pend;  // operation was a divide by zero

  logic [NW-1:0] abs_n;
  logic [DW:0]   trial;
  logic          fits;
  logic [DW:0]   p_step;

  // Operand magnitude and one restoring-division step.
  always_comb begin
    abs_n  = dividend[NW-1] ? (~dividend + 1'b1) : dividend;
    // p < dvs, so p fits in DW bits and the shifted value fits in DW+1 bits.
    trial  = {p[DW-1:0], mag[cnt]};
    fits   = (trial >= {1'b0, dvs});
    p_step = fits ? (trial - {1'b0, dvs}) : trial;
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StIdle;
      cnt         <= '0;
      mag         <= '0;
      q_acc       <= '0;
      dvs         <= '0;
      p           <= '0;
      neg         <= 1'b0;
      dz_pend     <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          // in_ready is high throughout IDLE, so in_valid alone is an accept.
          if (in_valid) begin
            in_ready <= 1'b0;
            neg      <= dividend[NW-1];
            mag      <= abs_n;
            dvs      <= divisor;
            p        <= '0;
            q_acc    <= '0;
            cnt      <= CW'(NW - 1);
            if (divisor == '0) begin
              // Zero divisor skips the iterations but still takes the FIX cycle
              // to load an all-zero result, so out_valid rises one edge after accept.
              dz_pend <= 1'b1;
              state   <= StFix;
            end else begin
              dz_pend <= 1'b0;
              state   <= StRun;
            end
          end
        end
        StRun: begin
          p          <= p_step;
          q_acc[cnt] <= fits;
          cnt        <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= StFix;
          end
        end
        StFix: begin
          // Negating q is safe for the minimum dividend: 2^(NW-1) negates to itself.
          quotient    <= neg ? (~q_acc + 1'b1) : q_acc;
          remainder   <= neg ? (~p + 1'b1) : p;
          div_by_zero <= dz_pend;
          out_valid   <= 1'b1;
          state       <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed and swept checks of seq_signed_divider with NW=5, DW=2.
module tb_seq_signed_divider;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] dividend;
  logic [1:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] quotient;
  logic [2:0] remainder;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_signed_divider #(
    .NW(5),
    .DW(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic [4:0] n;
    logic [1:0] d;
    logic [4:0] q;
    logic [2:0] r;
    logic       dz;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply one operation from IDLE (called #1 after an edge); returns the result and
  // the number of edges from accept until out_valid was seen. rnd randomises out_ready.
  task automatic run_op(input logic [4:0] n, input logic [1:0] d, input bit rnd,
                        output logic [4:0] q, output logic [2:0] r, output logic dz,
                        output int lat);
    int  guard;
    bit  took;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    dividend = n;
    divisor  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    guard = 0;
    do begin
      out_ready = (rnd && guard < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
      took = out_ready;
      @(posedge clk); #1;
      if (!took) begin
        chk("hold_result", {quotient, remainder, div_by_zero, out_valid}, {q, r, dz, 1'b1});
      end
      guard++;
    end while (!took);
    out_ready = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    logic [4:0] q;
    logic [2:0] r;
    logic       dz;
    int         lat;

    vecs[0]  = '{n: 5'b01011, d: 2'd2, q: 5'b00101, r: 3'b001, dz: 1'b0};
    vecs[1]  = '{n: 5'b11001, d: 2'd3, q: 5'b11110, r: 3'b111, dz: 1'b0};
    vecs[2]  = '{n: 5'b00111, d: 2'd3, q: 5'b00010, r: 3'b001, dz: 1'b0};
    vecs[3]  = '{n: 5'b10000, d: 2'd1, q: 5'b10000, r: 3'b000, dz: 1'b0};
    vecs[4]  = '{n: 5'b01111, d: 2'd3, q: 5'b00101, r: 3'b000, dz: 1'b0};
    vecs[5]  = '{n: 5'b00101, d: 2'd0, q: 5'b00000, r: 3'b000, dz: 1'b1};
    vecs[6]  = '{n: 5'b10001, d: 2'd2, q: 5'b11001, r: 3'b111, dz: 1'b0};
    vecs[7]  = '{n: 5'b01111, d: 2'd2, q: 5'b00111, r: 3'b001, dz: 1'b0};
    vecs[8]  = '{n: 5'b10000, d: 2'd3, q: 5'b11011, r: 3'b111, dz: 1'b0};
    vecs[9]  = '{n: 5'b11111, d: 2'd3, q: 5'b00000, r: 3'b111, dz: 1'b0};
    vecs[10] = '{n: 5'b00000, d: 2'd2, q: 5'b00000, r: 3'b000, dz: 1'b0};
    vecs[11] = '{n: 5'b10000, d: 2'd2, q: 5'b11000, r: 3'b000, dz: 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    foreach (vecs[i]) begin
      run_op(vecs[i].n, vecs[i].d, 1'b0, q, r, dz, lat);
      chk($sformatf("vec%0d_q", i), q, vecs[i].q);
      chk($sformatf("vec%0d_r", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), dz, vecs[i].dz);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].dz ? 1 : 6);
    end

    // Backpressure with in_valid held high; the second op must wait for IDLE.
    in_valid = 1'b1;
    dividend = 5'b01111;
    divisor  = 2'd3;
    @(posedge clk); #1;
    dividend = 5'b10001;
    divisor  = 2'd2;
    chk("bp_busy_in_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", lat, 6);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_q", quotient, 5'b00101);
      chk("bp_hold_r", remainder, 3'b000);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_no_accept", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accept", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp2_lat", lat, 6);
    chk("bp2_q", quotient, 5'b11001);
    chk("bp2_r", remainder, 3'b111);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset during the third RUN cycle.
    in_valid = 1'b1;
    dividend = 5'b01011;
    divisor  = 2'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(5'b11001, 2'd3, 1'b0, q, r, dz, lat);
    chk("postrst_q", q, 5'b11110);
    chk("postrst_r", r, 3'b111);
    chk("postrst_lat", lat, 6);

    // Exhaustive sweep against integer division, with random out_ready.
    for (int ni = 0; ni < 32; ni++) begin
      for (int di = 0; di < 4; di++) begin
        logic [4:0] n5;
        int         sn;
        int         eq;
        int         er;
        logic [4:0] eq5;
        logic [2:0] er3;
        n5 = 5'(ni);
        sn = $signed(n5);
        if (di == 0) begin
          eq = 0;
          er = 0;
        end else begin
          eq = sn / di;
          er = sn % di;
        end
        eq5 = 5'(eq);
        er3 = 3'(er);
        run_op(n5, 2'(di), 1'b1, q, r, dz, lat);
        chk($sformatf("sweep_q n=%0d d=%0d", sn, di), q, eq5);
        chk($sformatf("sweep_r n=%0d d=%0d", sn, di), r, er3);
        chk($sformatf("sweep_dbz n=%0d d=%0d", sn, di), dz, (di == 0) ? 1 : 0);
        chk($sformatf("sweep_lat n=%0d d=%0d", sn, di), lat, (di == 0) ? 1 : 6);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
